// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state encoding, data width and baud divisor helper.
// PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: down-counter with synchronous restart; bit_tick every CLKS cycles.
module uart_baud_tick #(
    parameter int CLKS = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int W = $clog2(CLKS + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= (restart || cnt == '0) ? W'(CLKS - 1) : cnt - 1'b1;

    assign bit_tick = !restart && cnt == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, 8N1 (or 8E1 with UART_TX_PARITY_EN) serial out, LSB first.
// The baud counter is held in restart while idle, so every frame starts phase-aligned.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       tx_n;
    logic       bit_tick;
    logic       accept;

    uart_baud_tick #(.CLKS(CPB)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart  (state == IDLE),
        .bit_tick (bit_tick)
    );

    assign in_ready = state == IDLE && !rst;
    assign busy     = state != IDLE;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end

    // The data byte stays intact in shreg and is indexed by bit_cnt, so parity is a plain XOR.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        tx_done   = 1'b0;
        case (state)
            IDLE:
                if (accept) begin
                    state_n   = START;
                    shreg_n   = in_data;
                    bit_cnt_n = '0;
                    tx_n      = 1'b0;
                end
            START:
                if (bit_tick) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            DATA:
                if (bit_tick) begin
                    if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
                        tx_n      = ^shreg;
`else
                        state_n   = STOP;
                        tx_n      = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = shreg[bit_cnt + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
            PARITY:
                if (bit_tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
`endif
            STOP:
                if (bit_tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        tx_done = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            default:
                state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized frame checks for uart_tx against a bit-level frame model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;
    localparam int CPB = 25_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [11:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy, tx_done;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] rxq[$];
    logic [7:0] rb;
    vec_t       vecs[$];

    uart_tx #(.CLK_FREQ(25_000_000), .BAUD_RATE(115200), .STOP_BITS(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Line-level receiver: mid-bit sampling after a falling edge on tx.
    initial forever begin
        @(negedge tx);
        repeat (CPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rb[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
`endif
            rxq.push_back(rb);
        end
    end

    // Frame bit i is the line level during bit period i: start, D0..D7, [parity], stop(s).
    function automatic logic [11:0] model(input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input bit hold, output int t0);
        int n;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("accept wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        t0 = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    // Entered at the first negedge after the accept edge; leaves at the idle negedge after the frame.
    task automatic check_frame(input logic [11:0] exp, input string name, input bit wiggle);
        int bad_tx = 0, bad_busy = 0, dones = 0, done_at = -1;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++) begin
                if (tx !== exp[b]) bad_tx++;
                if (busy !== 1'b1 || in_ready !== 1'b0) bad_busy++;
                if (tx_done === 1'b1) begin
                    dones++;
                    done_at = b * CPB + c;
                end
                if (wiggle) in_data = 8'($urandom);
                @(negedge clk);
            end
        chk({name, " tx bad cycles"}, 32'(bad_tx), 32'd0);
        chk({name, " busy/ready bad cycles"}, 32'(bad_busy), 32'd0);
        chk({name, " tx_done count"}, 32'(dones), 32'd1);
        chk({name, " tx_done cycle"}, 32'(done_at), 32'(NB * CPB - 1));
        chk({name, " idle {tx,busy,rdy,done}"}, 32'({tx, busy, in_ready, tx_done}), 32'b1010);
    endtask

    initial begin
        int t0, t1, n;
        logic [7:0] d;

`ifdef UART_TX_PARITY_EN
        vecs.push_back('{8'hA5, 12'h54A});
        vecs.push_back('{8'h07, 12'h60E});
        vecs.push_back('{8'h00, 12'h400});
        vecs.push_back('{8'hFF, 12'h5FE});
        vecs.push_back('{8'h3C, 12'h478});
        vecs.push_back('{8'h81, 12'h502});
`else
        vecs.push_back('{8'hA5, 12'h34A});
        vecs.push_back('{8'h00, 12'h200});
        vecs.push_back('{8'hFF, 12'h3FE});
        vecs.push_back('{8'h3C, 12'h278});
        vecs.push_back('{8'h81, 12'h302});
`endif

        #100;
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset tx_done", 32'(tx_done), 32'd0);
        #100 rst = 1'b0;
        @(negedge clk);
        chk("post-reset idle {tx,busy,rdy}", 32'({tx, busy, in_ready}), 32'b101);

        foreach (vecs[i]) begin
            start_frame(vecs[i].data, 1'b0, t0);
            check_frame(vecs[i].frame, $sformatf("vec%0d", i), 1'b0);
        end

        // Back-to-back with in_valid held across frames.
        rxq.delete();
        start_frame(8'h00, 1'b1, t0);
        check_frame(model(8'h00), "b2b first", 1'b0);
        in_data = 8'hFF;
        @(negedge clk);
        t1 = cyc;
        in_valid = 1'b0;
        check_frame(model(8'hFF), "b2b second", 1'b0);
        chk("b2b frame period", 32'(t1 - t0), 32'(NB * CPB + 1));
        n = 0;
        while (rxq.size() < 2 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        chk("rx byte count", 32'(rxq.size()), 32'd2);
        if (rxq.size() >= 2) begin
            chk("rx byte0", 32'(rxq[0]), 32'h00);
            chk("rx byte1", 32'(rxq[1]), 32'hFF);
        end

        // in_data churns while the frame is in flight with in_valid held.
        start_frame(8'h5A, 1'b1, t0);
        check_frame(model(8'h5A), "hold wiggle", 1'b1);
        in_valid = 1'b0;

        // Reset in the middle of D3.
        start_frame(8'h3C, 1'b0, t0);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midframe rst tx", 32'(tx), 32'd1);
        chk("midframe rst busy", 32'(busy), 32'd0);
        chk("midframe rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after rst in_ready", 32'(in_ready), 32'd1);
        start_frame(8'h81, 1'b0, t0);
        check_frame(model(8'h81), "after rst 0x81", 1'b0);

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            start_frame(d, 1'b0, t0);
            check_frame(model(d), $sformatf("rand%0d %02h", i, d), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
